// File: rtl/mult_hilo_ctrl_if.sv
// Bundle of the HI/LO controller's core-side request/write bus and its external multiplier link.
// The acc signal exists only when MULT_HILO_ACC_EN is defined.
interface mult_hilo_ctrl_if;
  logic        start;
  logic [31:0] op_a;
  logic [31:0] op_b;
  logic [31:0] mcnd;
  logic [31:0] mplr;
  logic [31:0] mult_hi;
  logic [31:0] mult_lo;
  logic        wr_hi;
  logic        wr_lo;
  logic [31:0] wr_data;
  logic [31:0] hi;
  logic [31:0] lo;
  logic        busy;
  logic        done;
`ifdef MULT_HILO_ACC_EN
  logic        acc;
`endif

  // The controller's view.
  modport slave (
    input  start, op_a, op_b, mult_hi, mult_lo, wr_hi, wr_lo, wr_data,
`ifdef MULT_HILO_ACC_EN
    input  acc,
`endif
    output mcnd, mplr, hi, lo, busy, done
  );

  // The view of whatever drives requests and hosts the multiplier.
  modport master (
    output start, op_a, op_b, mult_hi, mult_lo, wr_hi, wr_lo, wr_data,
`ifdef MULT_HILO_ACC_EN
    output acc,
`endif
    input  mcnd, mplr, hi, lo, busy, done
  );
endinterface

// File: rtl/mult_hilo_ctrl.sv
// HI/LO register controller for an external combinational multiplier with a fixed settle time.
// Optional accumulate mode (HI:LO += product) is enabled by defining MULT_HILO_ACC_EN.
module mult_hilo_ctrl #(
  parameter int unsigned LATENCY = 4
) (
  input logic              clk,
  input logic              rst,
  mult_hilo_ctrl_if.slave  bus
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  localparam logic [3:0] CNT_LOAD = 4'(LATENCY);

  state_t      state;
  state_t      state_nxt;
  logic [3:0]  cnt;
  logic [31:0] mcnd;
  logic [31:0] mplr;
  logic [31:0] hi;
  logic [31:0] lo;
  logic        busy;
  logic        done;
  logic        accept;
  logic        capture;
  logic [63:0] product;
  logic [63:0] result;

  assign product = {bus.mult_hi, bus.mult_lo};

`ifdef MULT_HILO_ACC_EN
  logic acc_q;

  // The carry out of bit 63 is intentionally dropped.
  assign result = acc_q ? ({hi, lo} + product) : product;
`else
  assign result = product;
`endif

  // ---------------------------------------------------------------
  // FSM
  // ---------------------------------------------------------------
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every
    // register samples the pre-edge values of the others.
    if (rst) state <= ST_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    // NOTE: every output of this block gets a default first, so no
    // path through the case can leave one unassigned and infer a latch.
    state_nxt = state;
    busy      = 1'b0;
    done      = 1'b0;
    accept    = 1'b0;
    capture   = 1'b0;
    unique case (state)
      ST_IDLE, ST_DONE: begin
        done      = (state == ST_DONE);
        accept    = bus.start;
        state_nxt = bus.start ? ST_WAIT : ST_IDLE;
      end
      ST_WAIT: begin
        busy = 1'b1;
        if (cnt == 4'd1) begin
          capture   = 1'b1;
          state_nxt = ST_DONE;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // ---------------------------------------------------------------
  // Datapath: operand latches, settle counter, HI/LO
  // ---------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt   <= '0;
      mcnd  <= '0;
      mplr  <= '0;
      hi    <= '0;
      lo    <= '0;
`ifdef MULT_HILO_ACC_EN
      acc_q <= 1'b0;
`endif
    end else if (busy) begin
      // Direct writes are dropped here; HI/LO move only on capture.
      if (capture) begin
        {hi, lo} <= result;
        cnt      <= '0;
      end else begin
        cnt <= cnt - 4'd1;
      end
    end else begin
      // A write coinciding with an accepted start lands now and is later
      // overwritten (or accumulated into) by the capture.
      if (bus.wr_hi) hi <= bus.wr_data;
      if (bus.wr_lo) lo <= bus.wr_data;
      if (accept) begin
        mcnd  <= bus.op_a;
        mplr  <= bus.op_b;
        cnt   <= CNT_LOAD;
`ifdef MULT_HILO_ACC_EN
        acc_q <= bus.acc;
`endif
      end
    end
  end

  assign bus.mcnd = mcnd;
  assign bus.mplr = mplr;
  assign bus.hi   = hi;
  assign bus.lo   = lo;
  assign bus.busy = busy;
  assign bus.done = done;

endmodule

// File: tb/tb_mult_hilo_ctrl.sv
// Self-checking bench for mult_hilo_ctrl: a transaction-level model compared every cycle,
// plus directed scenarios with literal expectations. Covers MULT_HILO_ACC_EN when defined.
module tb_mult_hilo_ctrl;
  localparam int LAT = 4;

  logic clk = 1'b0;
  logic rst;
  int   n_checks = 0;
  int   n_errors = 0;
  int   cyc = 0;

  mult_hilo_ctrl_if bus ();

  mult_hilo_ctrl #(.LATENCY(LAT)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // External multiplier: unsigned 64-bit product of the latched operands.
  assign {bus.mult_hi, bus.mult_lo} = 64'(bus.mcnd) * 64'(bus.mplr);

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h, expected %h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // ---------------------------------------------------------------
  // Reference model: tracks an operation as "cycles left to capture"
  // and computes the 64-bit result arithmetically.
  // ---------------------------------------------------------------
  logic [31:0] m_hi, m_lo, m_mcnd, m_mplr;
  logic [63:0] m_prod;
  logic        m_acc, m_done, m_valid = 1'b0;
  int          m_left;

  always @(posedge clk) begin
    if (rst) begin
      {m_hi, m_lo, m_mcnd, m_mplr} = '0;
      m_prod  = '0;
      m_acc   = 1'b0;
      m_done  = 1'b0;
      m_left  = 0;
      m_valid = 1'b1;
    end else if (m_left > 0) begin
      m_left = m_left - 1;
      m_done = (m_left == 0);
      if (m_left == 0)
        {m_hi, m_lo} = m_acc ? ({m_hi, m_lo} + m_prod) : m_prod;
    end else begin
      m_done = 1'b0;
      if (bus.wr_hi) m_hi = bus.wr_data;
      if (bus.wr_lo) m_lo = bus.wr_data;
      if (bus.start) begin
        m_mcnd = bus.op_a;
        m_mplr = bus.op_b;
        m_prod = 64'(bus.op_a) * 64'(bus.op_b);
        m_left = LAT;
`ifdef MULT_HILO_ACC_EN
        m_acc  = bus.acc;
`else
        m_acc  = 1'b0;
`endif
      end
    end
  end

  always @(negedge clk) begin
    cyc++;
    if (m_valid) begin
      check("hi",   bus.hi,   m_hi);
      check("lo",   bus.lo,   m_lo);
      check("mcnd", bus.mcnd, m_mcnd);
      check("mplr", bus.mplr, m_mplr);
      check("busy", bus.busy, (m_left > 0));
      check("done", bus.done, m_done);
    end
  end

  // ---------------------------------------------------------------
  // Directed stimulus
  // ---------------------------------------------------------------
  task automatic tick();
    @(negedge clk);
  endtask

  task automatic wait_done(input string nm);
    int n = 0;
    while (bus.done !== 1'b1 && n < 40) begin
      tick();
      n++;
    end
    check(nm, bus.done, 1'b1);
  endtask

  task automatic idle_inputs();
    bus.start   = 1'b0;
    bus.wr_hi   = 1'b0;
    bus.wr_lo   = 1'b0;
`ifdef MULT_HILO_ACC_EN
    bus.acc     = 1'b0;
`endif
  endtask

  initial begin
    int busy_n;
    int done_n;
    int pulses[$];

    rst         = 1'b1;
    bus.op_a    = '0;
    bus.op_b    = '0;
    bus.wr_data = '0;
    idle_inputs();
    repeat (2) tick();
    check("reset_hi",   bus.hi,   0);
    check("reset_busy", bus.busy, 0);
    check("reset_done", bus.done, 0);
    rst = 1'b0;
    tick();

    // Basic multiply 3 x 5.
    bus.start = 1'b1; bus.op_a = 32'd3; bus.op_b = 32'd5;
    tick();
    bus.start = 1'b0;
    check("t1_mcnd", bus.mcnd, 3);
    check("t1_mplr", bus.mplr, 5);
    busy_n = 0;
    while (bus.busy === 1'b1 && busy_n < 20) begin
      busy_n++;
      tick();
    end
    check("t1_busy_cycles", busy_n, LAT);
    check("t1_done", bus.done, 1);
    check("t1_hi", bus.hi, 0);
    check("t1_lo", bus.lo, 15);
    check("t1_model_lo", m_lo, 15);
    tick();
    check("t1_done_low", bus.done, 0);

    // Start during WAIT is ignored.
    bus.start = 1'b1; bus.op_a = 32'd3; bus.op_b = 32'd5;
    tick();
    bus.start = 1'b0;
    tick();
    bus.start = 1'b1; bus.op_a = 32'd7;
    tick();
    bus.start = 1'b0;
    done_n = 0;
    repeat (8) begin
      if (bus.done === 1'b1) done_n++;
      tick();
    end
    check("t2_done_pulses", done_n, 1);
    check("t2_mcnd", bus.mcnd, 3);

    // Direct writes in IDLE; dropped during WAIT.
    bus.wr_hi = 1'b1; bus.wr_data = 32'hDEADBEEF;
    tick();
    bus.wr_hi = 1'b0;
    check("t3_hi_write", bus.hi, 32'hDEADBEEF);
    bus.start = 1'b1; bus.op_a = 32'd2; bus.op_b = 32'd3;
    tick();
    bus.start = 1'b0;
    bus.wr_hi = 1'b1; bus.wr_lo = 1'b1; bus.wr_data = 32'h12345678;
    tick();
    tick();
    check("t3_hi_held", bus.hi, 32'hDEADBEEF);
    check("t3_lo_held", bus.lo, 15);
    bus.wr_hi = 1'b0; bus.wr_lo = 1'b0;
    wait_done("t3_wait_done");
    check("t3_hi_cap", bus.hi, 0);
    check("t3_lo_cap", bus.lo, 6);
    bus.wr_hi = 1'b1; bus.wr_lo = 1'b1; bus.wr_data = 32'hCAFEF00D;
    tick();
    idle_inputs();
    check("t3_both_hi", bus.hi, 32'hCAFEF00D);
    check("t3_both_lo", bus.lo, 32'hCAFEF00D);

    // Reset aborts a multiply at E2.
    bus.start = 1'b1; bus.op_a = 32'd3; bus.op_b = 32'd5;
    tick();
    bus.start = 1'b0;
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("t4_hi", bus.hi, 0);
    check("t4_lo", bus.lo, 0);
    check("t4_busy", bus.busy, 0);
    check("t4_mcnd", bus.mcnd, 0);
    done_n = 0;
    repeat (6) begin
      if (bus.done === 1'b1) done_n++;
      tick();
    end
    check("t4_no_done", done_n, 0);
    bus.start = 1'b1; bus.op_a = 32'd4; bus.op_b = 32'd5;
    tick();
    bus.start = 1'b0;
    check("t4_restart_busy", bus.busy, 1);
    wait_done("t4_wait_done");
    check("t4_lo_cap", bus.lo, 20);
    tick();

    // Simultaneous write and start: capture overwrites the write.
    bus.start = 1'b1; bus.op_a = 32'h0001_0000; bus.op_b = 32'h0001_0000;
    bus.wr_hi = 1'b1; bus.wr_lo = 1'b1; bus.wr_data = 32'hAAAA5555;
    tick();
    idle_inputs();
    check("t5_hi_written", bus.hi, 32'hAAAA5555);
    wait_done("t5_wait_done");
    check("t5_hi", bus.hi, 1);
    check("t5_lo", bus.lo, 0);
    tick();

    // Back-to-back with START held high.
    bus.start = 1'b1; bus.op_a = 32'hFFFFFFFF; bus.op_b = 32'hFFFFFFFF;
    for (int i = 0; i < 30; i++) begin
      if (bus.done === 1'b1) pulses.push_back(cyc);
      tick();
    end
    bus.start = 1'b0;
    check("t6_pulse_count_ok", (pulses.size() >= 4), 1);
    for (int i = 1; i < pulses.size(); i++)
      check("t6_done_period", pulses[i] - pulses[i-1], LAT + 1);
    wait_done("t6_wait_done");
    check("t6_hi", bus.hi, 32'hFFFFFFFE);
    check("t6_lo", bus.lo, 32'h00000001);
    tick();

`ifdef MULT_HILO_ACC_EN
    // Accumulate carries from LO into HI.
    bus.wr_hi = 1'b1; bus.wr_lo = 1'b1; bus.wr_data = 32'h0;
    tick();
    bus.wr_hi = 1'b0; bus.wr_data = 32'hFFFFFFFF;
    tick();
    bus.wr_lo = 1'b0;
    bus.start = 1'b1; bus.acc = 1'b1; bus.op_a = 32'd1; bus.op_b = 32'd1;
    tick();
    idle_inputs();
    wait_done("t7_wait_done");
    check("t7_hi", bus.hi, 32'h00000001);
    check("t7_lo", bus.lo, 32'h00000000);
    tick();
`endif

    repeat (2) tick();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/mult_hilo_ctrl.md
MULT_HILO_CTRL -- requirements
Module: mult_hilo_ctrl

Interface
REQ-001 The block SHALL have parameter LATENCY, default 4, giving the number of settle cycles allowed for the combinational multiplier; legal range 1..15.
REQ-002 The block SHALL have port CLK  input  1  system clock; all state updates on the rising edge.
REQ-003 The block SHALL have port RST  input  1  reset, synchronous, active-high.
REQ-004 The block SHALL have port START  input  1  multiply request.
REQ-005 The block SHALL have ports OP_A, OP_B  input  32  multiplicand and multiplier operands.
REQ-006 The block SHALL have ports MCND, MPLR  output  32  latched operands driven to the external multiplier.
REQ-007 The block SHALL have ports MULT_HI, MULT_LO  input  32  product returned from the external multiplier.
REQ-008 The block SHALL have ports WR_HI, WR_LO  input  1  direct register writes (move-to-HI/LO).
REQ-009 The block SHALL have port WR_DATA  input  32  write data for WR_HI and WR_LO.
REQ-010 The block SHALL have ports HI, LO  output  32  architectural HI/LO registers.
REQ-011 The block SHALL have port BUSY  output  1  high while in WAIT.
REQ-012 The block SHALL have port DONE  output  1  one-cycle completion pulse.
REQ-013 The block SHALL have port ACC  input  1  accumulate request; present only when MULT_HILO_ACC_EN is defined.

Function
REQ-014 States SHALL be IDLE, WAIT and DONE; DONE behaves as IDLE except that DONE=1.
REQ-015 In IDLE or DONE, a START=1 sampled at edge E0 SHALL:
- latch OP_A into MCND and OP_B into MPLR;
- load the counter with LATENCY;
- enter WAIT.
REQ-016 In WAIT, each edge SHALL do one of the following:
- if counter==1: capture MULT_HI/MULT_LO into HI/LO and enter DONE;
- otherwise: decrement the counter.
Capture therefore occurs at edge E0+LATENCY.
REQ-017 From DONE with START=0, the next edge SHALL enter IDLE; DONE is high for exactly one cycle per completed multiply.
REQ-018 START during WAIT SHALL be ignored, with no queuing.
REQ-019 START in DONE SHALL be accepted, giving back-to-back operation with no idle gap.
REQ-020 MCND and MPLR SHALL hold constant from the start-accept edge until the next accepted START.
REQ-021 BUSY SHALL equal 1 exactly when the state is WAIT.
REQ-022 In IDLE or DONE, WR_HI=1 SHALL load HI with WR_DATA and WR_LO=1 SHALL load LO with WR_DATA at that edge; both may be asserted together.
REQ-023 WR_HI and WR_LO SHALL be dropped while in WAIT; HI/LO are unchanged until capture.
REQ-024 Simultaneous START and WR_* in IDLE/DONE SHALL perform the write and start the multiply; the later capture overwrites the written value.
REQ-025 Operand signedness SHALL be the responsibility of the external multiplier; this block treats MULT_HI:MULT_LO as 64 opaque bits.

Reset
REQ-026 RST=1 at an edge SHALL force all of the following, overriding every other input:
- state IDLE, counter 0;
- HI=LO=0 and MCND=MPLR=0;
- BUSY=0, DONE=0;
- accumulate flag 0.
REQ-027 RST asserted during WAIT SHALL abort the operation with no capture; after release the block is in IDLE and accepts START on the first non-reset edge.

Configuration
REQ-028 With macro MULT_HILO_ACC_EN defined:
- ACC is sampled together with START and held through WAIT;
- if ACC was 1, capture writes {HI,LO} <= {HI,LO} + {MULT_HI,MULT_LO}, a 64-bit sum with the carry out of bit 63 discarded;
- if ACC was 0, capture overwrites HI/LO.
REQ-029 With MULT_HILO_ACC_EN undefined, the ACC port and the accumulate flag SHALL be absent and capture SHALL always overwrite HI/LO.

Verification
REQ-030 LATENCY=4; START with OP_A=3, OP_B=5; bench drives MULT_HI=0, MULT_LO=15 -> MCND=3 and MPLR=5 after E0; BUSY=1 for 4 cycles; HI=0 and LO=15 after E4; DONE=1 for one cycle only.
REQ-031 START at E0, then START with OP_A=7 at E2 -> second request ignored; MCND stays 3; a single DONE pulse.
REQ-032 WR_HI with WR_DATA=0xDEADBEEF in IDLE -> HI=0xDEADBEEF; repeated during WAIT -> HI unchanged until capture.
REQ-033 RST pulsed at E2 of a multiply -> no capture, no DONE; HI=LO=0, BUSY=0; a new START is then accepted normally.
REQ-034 MULT_HILO_ACC_EN defined; HI=0x00000000, LO=0xFFFFFFFF; ACC=1 with product 0x00000000_00000001 -> HI=0x00000001, LO=0x00000000.
REQ-035 Back-to-back: START held continuously -> a new operation is accepted in each DONE cycle; the DONE period equals LATENCY+1 cycles.
